// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer with lap-snapshot FIFO; STOPWATCH_ALARM_EN adds limit auto-stop.
// All outputs registered (1-cycle latency); a lap pushed into a full FIFO without a pop is dropped.

module stopwatch_lap_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic          do_wr, do_rd;
  logic [W-1:0]  head_nxt;

  // Head is registered, so it is computed from the post-update pointers;
  // an entry written this cycle that becomes the head bypasses the array.
  always_comb begin
    do_rd      = rd_rdy && (cnt != '0);
    do_wr      = wr_vld && ((cnt != (AW+1)'(DEPTH)) || do_rd);
    cnt_nxt    = cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rd_ptr_nxt = rd_ptr + AW'(do_rd);
    if (cnt_nxt == '0)
      head_nxt = '0;
    else if (do_wr && (rd_ptr_nxt == wr_ptr))
      head_nxt = wr_dat;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_dat <= '0;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      rd_vld <= (cnt_nxt != '0);
      rd_dat <= head_nxt;
      full   <= (cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module stopwatch_ctrl #(
  parameter int CNT_W     = 16,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_lap,
  input  logic             cmd_clear,
  input  logic [CNT_W-1:0] sw_count,
  input  logic [CNT_W-1:0] limit,
  output logic             sw_start,
  output logic             sw_stop,
  output logic             sw_rst,
  output logic             running,
  output logic             paused,
  output logic             lap_valid,
  output logic [CNT_W-1:0] lap_data,
  input  logic             lap_pop,
  output logic             lap_full,
  output logic             lap_ovf,
  output logic             alarm
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t state;
  logic   lap_push, lap_drop, hit;

  always_comb begin
    lap_push = cmd_lap && !cmd_clear && (state != IDLE);
    lap_drop = lap_push && lap_full && !lap_pop;
  end

`ifdef STOPWATCH_ALARM_EN
  assign hit = (state == RUN) && (limit != '0) && (sw_count >= limit);
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sw_start <= 1'b0;
      sw_stop  <= 1'b0;
      sw_rst   <= 1'b0;
      running  <= 1'b0;
      paused   <= 1'b0;
      lap_ovf  <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      sw_start <= 1'b0;
      sw_stop  <= 1'b0;
      sw_rst   <= 1'b0;
      if (lap_drop) lap_ovf <= 1'b1;
      // A command that is ignored in the current state does not mask a lower-priority one.
      if (cmd_clear) begin
        sw_rst  <= 1'b1;
        state   <= IDLE;
        running <= 1'b0;
        paused  <= 1'b0;
        lap_ovf <= 1'b0;
        alarm   <= 1'b0;
      end else if ((state == RUN) && (cmd_stop || hit)) begin
        sw_stop <= 1'b1;
        state   <= PAUSE;
        running <= 1'b0;
        paused  <= 1'b1;
        if (hit) alarm <= 1'b1;
      end else if ((state != RUN) && cmd_start) begin
        sw_start <= 1'b1;
        state    <= RUN;
        running  <= 1'b1;
        paused   <= 1'b0;
        alarm    <= 1'b0;
      end
    end
  end

  stopwatch_lap_fifo #(
    .W     (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (cmd_clear),
    .wr_vld (lap_push),
    .wr_dat (sw_count),
    .rd_rdy (lap_pop),
    .rd_vld (lap_valid),
    .rd_dat (lap_data),
    .full   (lap_full)
  );
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed test-plan sequences then random commands vs a queue-based model.
module tb_stopwatch_ctrl;
  localparam int CNT_W     = 16;
  localparam int LAP_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, cmd_start, cmd_stop, cmd_lap, cmd_clear, lap_pop;
  logic [CNT_W-1:0] sw_count, limit, lap_data;
  logic             sw_start, sw_stop, sw_rst, running, paused;
  logic             lap_valid, lap_full, lap_ovf, alarm;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_e;
  mode_e            m_mode;
  logic [CNT_W-1:0] m_q[$];
  bit               m_ovf, m_alarm, m_start, m_stop, m_rst;

  stopwatch_ctrl #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_lap(cmd_lap), .cmd_clear(cmd_clear), .sw_count(sw_count), .limit(limit),
    .sw_start(sw_start), .sw_stop(sw_stop), .sw_rst(sw_rst), .running(running),
    .paused(paused), .lap_valid(lap_valid), .lap_data(lap_data), .lap_pop(lap_pop),
    .lap_full(lap_full), .lap_ovf(lap_ovf), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit push, pop, hit;
    m_start = 0; m_stop = 0; m_rst = 0;
    if (rst) begin
      m_mode = M_IDLE; m_q.delete(); m_ovf = 0; m_alarm = 0;
      return;
    end
    if (cmd_clear) begin
      m_rst = 1; m_mode = M_IDLE; m_q.delete(); m_ovf = 0; m_alarm = 0;
      return;
    end
    hit = 0;
`ifdef STOPWATCH_ALARM_EN
    hit = (m_mode == M_RUN) && (limit != 0) && (sw_count >= limit);
`endif
    push = cmd_lap && (m_mode != M_IDLE);
    pop  = lap_pop && (m_q.size() > 0);
    if (push && !pop && (m_q.size() == LAP_DEPTH)) m_ovf = 1;
    else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(sw_count);
    end
    if ((m_mode == M_RUN) && (cmd_stop || hit)) begin
      m_stop = 1; m_mode = M_PAUSE;
      if (hit) m_alarm = 1;
    end else if ((m_mode != M_RUN) && cmd_start) begin
      m_start = 1; m_mode = M_RUN; m_alarm = 0;
    end
  endtask

  task automatic check_all();
    chk("sw_start",  sw_start,  m_start);
    chk("sw_stop",   sw_stop,   m_stop);
    chk("sw_rst",    sw_rst,    m_rst);
    chk("running",   running,   m_mode == M_RUN);
    chk("paused",    paused,    m_mode == M_PAUSE);
    chk("lap_valid", lap_valid, m_q.size() != 0);
    chk("lap_data",  lap_data,  (m_q.size() != 0) ? m_q[0] : '0);
    chk("lap_full",  lap_full,  m_q.size() == LAP_DEPTH);
    chk("lap_ovf",   lap_ovf,   m_ovf);
    chk("alarm",     alarm,     m_alarm);
  endtask

  // Inputs are set here, sampled at the next rising edge, outputs checked 1 ns later.
  task automatic drive(input bit s, input bit p, input bit l, input bit c, input bit pp,
                       input logic [CNT_W-1:0] cnt);
    cmd_start = s; cmd_stop = p; cmd_lap = l; cmd_clear = c; lap_pop = pp; sw_count = cnt;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    cmd_start = 0; cmd_stop = 0; cmd_lap = 0; cmd_clear = 0; lap_pop = 0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, sw_count);
  endtask

  initial begin
    rst = 1; cmd_start = 0; cmd_stop = 0; cmd_lap = 0; cmd_clear = 0; lap_pop = 0;
    sw_count = '0; limit = '0;
    m_mode = M_IDLE; m_ovf = 0; m_alarm = 0;
    idle();
    rst = 0;
    chk("reset_running", running, 0);
    chk("reset_lap_data", lap_data, 0);

    // Start pulse, then a repeated start while running
    drive(1, 0, 0, 0, 0, 16'h0000);
    chk("plan_start_pulse", sw_start, 1);
    idle();
    chk("plan_start_one_cycle", sw_start, 0);
    drive(1, 0, 0, 0, 0, 16'h0001);
    chk("plan_no_dup_start", sw_start, 0);

    // Two laps and pops
    drive(0, 0, 1, 0, 0, 16'h0007);
    drive(0, 0, 1, 0, 0, 16'h000C);
    chk("plan_lap_head0", lap_data, 16'h0007);
    drive(0, 0, 0, 0, 1, 16'h000D);
    chk("plan_lap_head1", lap_data, 16'h000C);
    drive(0, 0, 0, 0, 1, 16'h000E);
    chk("plan_lap_empty", lap_valid, 0);

    // Overflow: five laps with no pops
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, CNT_W'(16'h0021 + i));
    chk("plan_full", lap_full, 1);
    chk("plan_ovf", lap_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      chk("plan_ovf_entry", lap_data, CNT_W'(16'h0021 + i));
      drive(0, 0, 0, 0, 1, 16'h0030);
    end

    // Fresh run: lap + pop when full keeps it full with no overflow
    drive(0, 0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, CNT_W'(16'h0040 + i));
    drive(0, 0, 1, 0, 1, 16'h0050);
    chk("plan_pushpop_ovf", lap_ovf, 0);
    chk("plan_pushpop_full", lap_full, 1);
    chk("plan_pushpop_head", lap_data, 16'h0041);

    // Stop then start; then stop+start together from RUN
    drive(0, 1, 0, 0, 0, 16'h0051);
    chk("plan_stop_pulse", sw_stop, 1);
    chk("plan_paused", paused, 1);
    drive(1, 0, 0, 0, 0, 16'h0052);
    chk("plan_resume", running, 1);
    drive(1, 1, 0, 0, 0, 16'h0053);
    chk("plan_stop_wins_start", sw_start, 0);
    chk("plan_stop_wins_paused", paused, 1);

    // Clear with same-cycle lap and pop
    drive(1, 0, 0, 0, 0, 16'h0054);
    drive(0, 0, 0, 0, 0, 16'h0054);
    drive(0, 0, 1, 1, 1, 16'h0055);
    chk("plan_clear_rst", sw_rst, 1);
    chk("plan_clear_empty", lap_valid, 0);
    chk("plan_clear_idle", running | paused, 0);

    // Reset mid-run
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 0, 1, 0, 0, 16'h0003);
    rst = 1;
    idle();
    rst = 0;
    chk("plan_rst_midrun", {sw_start, sw_stop, sw_rst, running, paused, lap_valid,
                            lap_full, lap_ovf, alarm}, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      limit = CNT_W'($urandom_range(0, 40));
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0, CNT_W'($urandom_range(0, 40)));
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
